// File: rtl/multi_byte_add_sequencer_pkg.sv
// multi_byte_add_sequencer_pkg: shared FSM state type and sizing constants for the byte-serial adder
package multi_byte_add_sequencer_pkg;
  localparam int BYTE_W = 8;
  localparam int DEFAULT_NUM_BYTES = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_byte_add_sequencer_adder.sv
// eight_bit_adder: one byte slice with carry in and carry out
module eight_bit_adder
  import multi_byte_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};
endmodule

// File: rtl/multi_byte_add_sequencer.sv
// multi_byte_add_sequencer: adds two NUM_BYTES-wide operands one byte per cycle through a single slice adder
module multi_byte_add_sequencer
  import multi_byte_add_sequencer_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] op_a,
  input  logic [BYTE_W*NUM_BYTES-1:0] op_b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] result,
  output logic                      cout
);
  localparam int IDX_W = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [BYTE_W-1:0] slice_sum;
  logic slice_co;
  eight_bit_adder u_slice (
    .a (a_q[idx_q]),
    .b (b_q[idx_q]),
    .ci(carry_q),
    .s (slice_sum),
    .co(slice_co)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = op_a;
      b_d     = op_b;
      carry_d = cin;
      idx_d   = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      result_d[idx_q] = slice_sum;
      carry_d         = slice_co;
      idx_d           = idx_q + 1'b1;
      cout_d          = (idx_q == LAST) ? slice_co : cout_q;
      state_d         = (idx_q == LAST) ? DONE : ADD;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// tb_multi_byte_add_sequencer: randomized and directed checks against a cycle-level arithmetic model
module tb_multi_byte_add_sequencer;
  localparam int N = 4;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 0;
  logic in_ready, out_valid, cout;
  logic [31:0] op_a = '0, op_b = '0, result;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit armed = 0;
  bit m_busy = 0;
  int m_k = 0;
  logic [32:0] m_sum = '0;
  logic [31:0] m_res = '0;
  logic m_cout = 0;

  multi_byte_add_sequencer #(.NUM_BYTES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accepted operation reveals one more low byte of the true sum per cycle,
  // and the final sum/carry become the held result once all bytes are done.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_k = 0; m_res = '0; m_cout = 0; armed = 1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_k = 0;
        m_sum = {1'b0, op_a} + {1'b0, op_b} + 33'(cin);
      end
    end else if (m_k < N) begin
      m_k++;
      if (m_k == N) begin m_res = m_sum[31:0]; m_cout = m_sum[32]; end
    end else if (out_ready) m_busy = 0;
  end

  always @(negedge clk) begin
    logic [31:0] mask, exp_res;
    if (armed) begin
      mask = (32'd1 << (8 * m_k)) - 32'd1;
      exp_res = (m_busy && m_k < N) ? ((m_sum[31:0] & mask) | (m_res & ~mask)) : m_res;
      chk("in_ready", 64'(in_ready), 64'(!m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_busy && m_k == N));
      chk("result", 64'(result), 64'(exp_res));
      chk("cout", 64'(cout), 64'(m_cout));
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int stall, input logic [31:0] er, input logic ec);
    int t0, guard;
    logic [31:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("ready_timeout", 64'(in_ready), 64'd1);
    op_a = a; op_b = b; cin = c; in_valid = 1; out_ready = 0;
    @(negedge clk);
    t0 = cyc;
    guard = 0;
    while (!out_valid && guard < 50) begin
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom; cin = 1'($urandom);
      @(negedge clk); guard++;
    end
    chk("latency", 64'(cyc - t0), 64'(N));
    chk("op_result", 64'(result), 64'(er));
    chk("op_cout", 64'(cout), 64'(ec));
    held = result;
    repeat (stall) begin in_valid = 1'($urandom); @(negedge clk); end
    chk("stall_result", 64'(result), 64'(held));
    chk("stall_valid", 64'(out_valid), 64'd1);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic c;
    logic [32:0] s;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    run_op(32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'hFFFFFFFE, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF, 1'b1);
    run_op(32'hFFFFFFFF, 32'h0, 1'b1, 0, 32'h00000000, 1'b1);
    run_op(32'h80, 32'h80, 1'b0, 5, 32'h00000100, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom);
      if (i % 5 == 0) a = 32'hFFFFFFFF - b;
      s = {1'b0, a} + {1'b0, b} + 33'(c);
      run_op(a, b, c, int'($urandom_range(0, 3)), s[31:0], s[32]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    op_a = 32'h12345678; op_b = 32'h11111111; cin = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1; in_valid = 1; out_ready = 1;
    @(negedge clk);
    rst = 0; in_valid = 0; out_ready = 0;
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_pulse", 64'(out_valid), 64'd0);
    end
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1, 32'h00000100, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
